// File: rtl/nvram_pkg.sv
// nvram_pkg: shared FSM states and constants for nvram_upload
package nvram_pkg;
  typedef enum logic [1:0] {IDLE, ARB, READ, CAPT} state_e;
  localparam logic [7:0] OOR_BYTE = 8'hFF;
endpackage

// File: rtl/nvram_upload.sv
// nvram_upload: serves NVRAM bytes to the HPS during an ioctl upload session
// Ports:
//   clk_sys, reset_n             system clock, asynchronous active-low reset
//   ioctl_upload, ioctl_index    upload session flag and its file index
//   ioctl_rd, ioctl_addr         one-cycle byte request and its address
//   ioctl_din, ioctl_wait        returned byte and request-in-progress flag
//   mem_addr, mem_rd, mem_data   NVRAM read port, data valid one cycle after mem_rd
//   mem_busy                     core owns the NVRAM port, reads are held off
//   done                         one-cycle pulse when a matching session ends
// Build option NVRAM_CHECKSUM_EN: address DEPTH returns the two's-complement
// of the sum of in-range bytes served since the session started.
module nvram_upload
  import nvram_pkg::*;
#(
  parameter int         ADDR_W       = 10,
  parameter logic [7:0] UPLOAD_INDEX = 8'd4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  input  logic              mem_busy,
  output logic              done
);
  localparam logic [24:0] DEPTH = 25'(1) << ADDR_W;
  state_e state_q, state_d;
  logic up_q, match_q, match_d, oor_q, oor_d, done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0] din_q, din_d, oor_byte;
  logic hit, rise, fall, accept;
  assign hit = ioctl_index == UPLOAD_INDEX;
  assign rise = ioctl_upload & ~up_q;
  assign fall = up_q & ~ioctl_upload;
  assign accept = state_q == IDLE && ioctl_upload && hit && ioctl_rd;
`ifdef NVRAM_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic csel_q, csel_d;
  // a CAPT cut short by the upload falling does not serve its byte
  always_comb begin
    csel_d = accept ? ioctl_addr == DEPTH : csel_q;
    sum_d = rise ? 8'h00 : (state_q == CAPT && !oor_q && !fall) ? sum_q + mem_data : sum_q;
  end
  assign oor_byte = csel_q ? ~sum_q + 8'd1 : OOR_BYTE;
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= 8'h00;
      csel_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      csel_q <= csel_d;
    end
  end
`else
  assign oor_byte = OOR_BYTE;
`endif
  always_comb begin
    state_d = state_q;
    din_d = din_q;
    case (state_q)
      IDLE: state_d = !accept ? IDLE : ioctl_addr >= DEPTH ? CAPT : ARB;
      ARB:  state_d = mem_busy ? ARB : READ;
      READ: state_d = CAPT;
      CAPT: begin
        state_d = IDLE;
        din_d = oor_q ? oor_byte : mem_data;
      end
    endcase
    if (fall) begin
      state_d = IDLE;
      din_d = din_q;
    end
    addr_d = accept ? ioctl_addr[ADDR_W-1:0] : addr_q;
    oor_d = accept ? ioctl_addr >= DEPTH : oor_q;
    match_d = rise ? hit : match_q;
    done_d = fall & match_q;
  end
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      up_q <= 1'b0;
      match_q <= 1'b0;
      oor_q <= 1'b0;
      done_q <= 1'b0;
      addr_q <= '0;
      din_q <= 8'h00;
    end else begin
      state_q <= state_d;
      up_q <= ioctl_upload;
      match_q <= match_d;
      oor_q <= oor_d;
      done_q <= done_d;
      addr_q <= addr_d;
      din_q <= din_d;
    end
  end
  assign ioctl_din = din_q;
  assign ioctl_wait = state_q != IDLE;
  assign mem_rd = state_q == READ;
  assign mem_addr = addr_q;
  assign done = done_q;
endmodule

// File: tb/tb_nvram_upload.sv
// tb_nvram_upload: randomized and directed checks of nvram_upload against a byte-level model
module tb_nvram_upload;
  localparam int ADDR_W = 10;
  localparam int DEPTH = 1 << ADDR_W;
`ifdef NVRAM_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  logic clk_sys = 1'b0, reset_n = 1'b0, ioctl_upload = 1'b0, ioctl_rd = 1'b0, mem_busy = 1'b0;
  logic [7:0] ioctl_index = 8'd0, mem_data = 8'd0, ioctl_din;
  logic [24:0] ioctl_addr = 25'd0;
  logic ioctl_wait, mem_rd, done;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0] ram [DEPTH];
  int compared = 0, mismatched = 0, done_cnt = 0, busy_viol = 0;
  logic [7:0] m_din = 8'h00, m_sum = 8'h00;
  always #5 clk_sys = ~clk_sys;
  nvram_upload #(.ADDR_W(ADDR_W), .UPLOAD_INDEX(8'd4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_data(mem_data), .mem_busy(mem_busy), .done(done)
  );
  always @(posedge clk_sys) begin
    if (mem_rd) mem_data <= ram[mem_addr];
    if (mem_rd && mem_busy) busy_viol <= busy_viol + 1;
  end
  always @(negedge clk_sys) if (done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic new_session(input logic [7:0] idx);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    ioctl_index = idx;
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    m_sum = 8'h00;
  endtask

  task automatic do_req(input string tag, input logic [24:0] a, input int busy);
    int wcnt, rcnt, n;
    logic [ADDR_W-1:0] ra;
    logic acc;
    logic [7:0] exp;
    acc = ioctl_upload && ioctl_index == 8'd4;
    exp = a < DEPTH ? ram[a[ADDR_W-1:0]] :
          (CSUM && a == DEPTH) ? 8'((256 - int'(m_sum)) % 256) : 8'hFF;
    ioctl_addr = a;
    ioctl_rd = 1'b1;
    mem_busy = busy > 0;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    wcnt = 0;
    rcnt = 0;
    ra = '0;
    for (n = 0; n < 100 && ioctl_wait; n++) begin
      if (mem_rd) begin
        rcnt++;
        ra = mem_addr;
      end
      wcnt++;
      if (wcnt > busy) mem_busy = 1'b0;
      @(negedge clk_sys);
    end
    mem_busy = 1'b0;
    if (acc) begin
      if (a < DEPTH) m_sum = 8'((int'(m_sum) + int'(exp)) % 256);
      m_din = exp;
    end
    check({tag, " bound"}, 32'(n < 100), 32'd1);
    check({tag, " wait"}, wcnt, acc ? (a < DEPTH ? 3 + busy : 1) : 0);
    check({tag, " rd"}, rcnt, (acc && a < DEPTH) ? 1 : 0);
    if (rcnt > 0) check({tag, " addr"}, 32'(ra), 32'(a[ADDR_W-1:0]));
    check({tag, " din"}, 32'(ioctl_din), 32'(m_din));
  endtask

  initial begin
    int d0, r;
    logic [24:0] a;
    for (int i = 0; i < DEPTH; i++) ram[i] = 8'($urandom);
    ioctl_index = 8'd4;
    ioctl_upload = 1'b1;
    #12;
    check("rst din", 32'(ioctl_din), 32'h00);
    check("rst wait", 32'(ioctl_wait), 32'd0);
    check("rst rd", 32'(mem_rd), 32'd0);
    check("rst addr", 32'(mem_addr), 32'd0);
    check("rst done", 32'(done), 32'd0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    ram[5] = 8'h3C;
    do_req("r036", 25'h005, 0);
    check("r036 lit", 32'(ioctl_din), 32'h3C);
    ram[5] = 8'hA7;
    do_req("r037", 25'h005, 10);
    check("r037 lit", 32'(ioctl_din), 32'hA7);
    new_session(8'd4);
    ram[1] = 8'h01;
    ram[2] = 8'h02;
    do_req("r038 b1", 25'h001, 0);
    do_req("r038 b2", 25'h002, 1);
    do_req("r038 oor", 25'h400, 0);
    check("r038 lit", 32'(ioctl_din), CSUM ? 32'hFD : 32'hFF);
    do_req("oor 401", 25'h401, 0);
    do_req("oor max", 25'h1FFFFFF, 0);
    do_req("r038 b1 again", 25'h001, 0);
    ioctl_index = 8'd0;
    do_req("r039", 25'h007, 0);
    ioctl_index = 8'd4;
    d0 = done_cnt;
    ioctl_addr = 25'h009;
    ioctl_rd = 1'b1;
    mem_busy = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    @(negedge clk_sys);
    check("r040 arb wait", 32'(ioctl_wait), 32'd1);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    check("r040 wait", 32'(ioctl_wait), 32'd0);
    check("r040 rd", 32'(mem_rd), 32'd0);
    check("r040 done", 32'(done), 32'd1);
    check("r040 din", 32'(ioctl_din), 32'(m_din));
    @(negedge clk_sys);
    @(negedge clk_sys);
    mem_busy = 1'b0;
    check("r040 pulses", done_cnt - d0, 32'd1);
    ioctl_index = 8'd0;
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    d0 = done_cnt;
    ioctl_upload = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("idx0 no done", done_cnt - d0, 32'd0);
    new_session(8'd4);
    for (int k = 0; k < 24; k++) begin
      r = int'($urandom_range(0, 9));
      a = r < 7 ? 25'($urandom_range(0, DEPTH - 1)) : r == 7 ? 25'(DEPTH) :
          25'($urandom_range(DEPTH + 1, 32'h1FFFFFF));
      if (r == 9) ioctl_index = 8'($urandom_range(5, 255));
      do_req("rand", a, int'($urandom_range(0, 3)));
      ioctl_index = 8'd4;
      if ($urandom_range(0, 7) == 0) new_session(8'd4);
    end
    do_req("rand csum", 25'(DEPTH), 0);
    ioctl_addr = 25'h003;
    ioctl_rd = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    @(negedge clk_sys);
    check("r041 in read", 32'(mem_rd), 32'd1);
    d0 = done_cnt;
    #1 reset_n = 1'b0;
    #1;
    check("r041 din", 32'(ioctl_din), 32'h00);
    check("r041 wait", 32'(ioctl_wait), 32'd0);
    check("r041 rd", 32'(mem_rd), 32'd0);
    check("r041 addr", 32'(mem_addr), 32'd0);
    check("r041 done", 32'(done), 32'd0);
    m_din = 8'h00;
    m_sum = 8'h00;
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    check("r041 no done", done_cnt - d0, 32'd0);
    do_req("post rst csum", 25'(DEPTH), 0);
    do_req("post rst", 25'h0AB, 2);
    d0 = done_cnt;
    ioctl_upload = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("post rst done", done_cnt - d0, 32'd1);
    check("busy reads", busy_viol, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
